// File: rtl/ctrl_pkg.sv
// Shared opcode/funct constants, ALU and load-width encodings, and the decoded control flags.
// Optional jump support is compiled in with CTRL_JUMP_EN.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALU_SLL = 4'd0;
  localparam logic [3:0] ALU_SRL = 4'd1;
  localparam logic [3:0] ALU_SRA = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_AND = 4'd5;
  localparam logic [3:0] ALU_OR  = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd8;
  localparam logic [3:0] ALU_SLT = 4'd9;

  localparam logic [1:0] RDW_WORD = 2'd0;
  localparam logic [1:0] RDW_HALF = 2'd1;
  localparam logic [1:0] RDW_BYTE = 2'd2;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic       load_signed;
    logic       illegal;
    logic [1:0] mem_rd_width;
`ifdef CTRL_JUMP_EN
    logic       jump;
    logic       link;
`endif
  } ctrl_flags_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS instruction decoder feeding the ID/EX register.
// J/JAL/JR are decoded only with CTRL_JUMP_EN; otherwise they fall into the illegal path.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned LANES   = 4
) (
  input  logic [31:0]        instr,
  output ctrl_flags_t        flags_c,
  output logic [LANES-1:0]   mem_write_c,
  output logic [ALUOP_W-1:0] alu_op_c,
  output logic [REG_AW-1:0]  dest_reg_c
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       legal;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[10:6];

  always_comb begin
    flags_c     = '0;
    mem_write_c = '0;
    alu_op_c    = ALUOP_W'(ALU_ADD);
    legal       = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        flags_c.reg_dst   = 1'b1;
        flags_c.reg_write = 1'b1;
        case (funct)
          FN_SLL, FN_SLLV: alu_op_c = ALUOP_W'(ALU_SLL);
          FN_SRL, FN_SRLV: alu_op_c = ALUOP_W'(ALU_SRL);
          FN_SRA, FN_SRAV: alu_op_c = ALUOP_W'(ALU_SRA);
          FN_ADD:          alu_op_c = ALUOP_W'(ALU_ADD);
          FN_SUB:          alu_op_c = ALUOP_W'(ALU_SUB);
          FN_AND:          alu_op_c = ALUOP_W'(ALU_AND);
          FN_OR:           alu_op_c = ALUOP_W'(ALU_OR);
          FN_XOR:          alu_op_c = ALUOP_W'(ALU_XOR);
          FN_NOR:          alu_op_c = ALUOP_W'(ALU_NOR);
          FN_SLT:          alu_op_c = ALUOP_W'(ALU_SLT);
`ifdef CTRL_JUMP_EN
          FN_JR: begin
            flags_c.reg_dst   = 1'b0;
            flags_c.reg_write = 1'b0;
            flags_c.jump      = 1'b1;
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      // opcode[2] separates unsigned loads; opcode[1:0] gives the access size
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
        flags_c.mem_to_reg  = 1'b1;
        flags_c.alu_src     = 1'b1;
        flags_c.reg_write   = 1'b1;
        flags_c.load_signed = ~opcode[2];
        case (opcode[1:0])
          2'b00:   flags_c.mem_rd_width = RDW_BYTE;
          2'b01:   flags_c.mem_rd_width = RDW_HALF;
          default: flags_c.mem_rd_width = RDW_WORD;
        endcase
      end
      OP_SB: begin flags_c.alu_src = 1'b1; mem_write_c = LANES'(4'b0001); end
      OP_SH: begin flags_c.alu_src = 1'b1; mem_write_c = LANES'(4'b0011); end
      OP_SW: begin flags_c.alu_src = 1'b1; mem_write_c = '1; end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
        flags_c.alu_src   = 1'b1;
        flags_c.reg_write = 1'b1;
        case (opcode)
          OP_SLTI: alu_op_c = ALUOP_W'(ALU_SLT);
          OP_ANDI: alu_op_c = ALUOP_W'(ALU_AND);
          OP_ORI:  alu_op_c = ALUOP_W'(ALU_OR);
          OP_XORI: alu_op_c = ALUOP_W'(ALU_XOR);
          default: alu_op_c = ALUOP_W'(ALU_ADD);
        endcase
      end
      OP_BEQ, OP_BNE: begin
        flags_c.branch = 1'b1;
        alu_op_c       = ALUOP_W'(ALU_SUB);
      end
`ifdef CTRL_JUMP_EN
      OP_J: flags_c.jump = 1'b1;
      OP_JAL: begin
        flags_c.jump      = 1'b1;
        flags_c.link      = 1'b1;
        flags_c.reg_write = 1'b1;
      end
`endif
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      flags_c         = '0;
      flags_c.illegal = 1'b1;
      mem_write_c     = '0;
      alu_op_c        = '1;
    end

    dest_reg_c = flags_c.reg_dst ? REG_AW'(instr[15:11]) : REG_AW'(instr[20:16]);
`ifdef CTRL_JUMP_EN
    if (flags_c.link) dest_reg_c = REG_AW'(5'd31);
`endif
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID-stage control: decode into ID/EX registers with load-use stall, branch flush and external hold.
// Exposes jump/link outputs only when CTRL_JUMP_EN is defined.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned ALUOP_W   = 4,
  parameter int unsigned LANES     = 4,
  parameter int unsigned FLUSH_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  input  logic               branch_taken,
  input  logic               ext_stall,
  output logic               instr_ready,
  output logic               ex_valid,
  output logic               reg_dst,
  output logic               branch,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic               reg_write,
  output logic [LANES-1:0]   mem_write,
  output logic [1:0]         mem_rd_width,
  output logic               load_signed,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [REG_AW-1:0]  dest_reg,
  output logic               illegal
`ifdef CTRL_JUMP_EN
  ,
  output logic               jump,
  output logic               link
`endif
);

  localparam int unsigned CNT_W = 2;
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_c, load_en, load_bubble, run_path, hazard_c;

  ctrl_flags_t        dec_flags, flags_q;
  logic [LANES-1:0]   dec_mem_write, mem_write_q;
  logic [ALUOP_W-1:0] dec_alu_op, alu_op_q;
  logic [REG_AW-1:0]  dec_dest_reg, dest_reg_q;
  logic               ex_valid_q;

  ctrl_decode #(
    .REG_AW (REG_AW),
    .ALUOP_W(ALUOP_W),
    .LANES  (LANES)
  ) u_decode (
    .instr      (instr),
    .flags_c    (dec_flags),
    .mem_write_c(dec_mem_write),
    .alu_op_c   (dec_alu_op),
    .dest_reg_c (dec_dest_reg)
  );

  // Load in EX writing a register the ID instruction reads
  assign hazard_c = instr_valid & ex_valid_q & flags_q.mem_to_reg & (dest_reg_q != '0) &
                    ((dest_reg_q == REG_AW'(instr[25:21])) | (dest_reg_q == REG_AW'(instr[20:16])));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_c     = 1'b0;
    load_en     = 1'b0;
    load_bubble = 1'b0;
    run_path    = 1'b0;
    if (branch_taken) begin
      load_en     = 1'b1;
      load_bubble = 1'b1;
      ready_c     = 1'b1;
      cnt_d       = CNT_W'(FLUSH_CYC - 1);
      state_d     = ST_FLUSH;
    end else if (!ext_stall) begin
      case (state_q)
        ST_LU_STALL: begin
          load_en     = 1'b1;
          load_bubble = ~instr_valid;
          ready_c     = 1'b1;
          state_d     = ST_RUN;
        end
        ST_FLUSH: begin
          if (cnt_q != '0) begin
            load_en     = 1'b1;
            load_bubble = 1'b1;
            ready_c     = 1'b1;
            cnt_d       = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
          end else begin
            run_path = 1'b1;
          end
        end
        default: run_path = 1'b1;
      endcase
      if (run_path) begin
        load_en = 1'b1;
        if (hazard_c) begin
          load_bubble = 1'b1;
          state_d     = ST_LU_STALL;
        end else begin
          load_bubble = ~instr_valid;
          ready_c     = 1'b1;
          state_d     = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      flags_q     <= '0;
      mem_write_q <= '0;
      alu_op_q    <= '0;
      dest_reg_q  <= '0;
    end else if (load_en) begin
      ex_valid_q  <= ~load_bubble;
      flags_q     <= load_bubble ? '0 : dec_flags;
      mem_write_q <= load_bubble ? '0 : dec_mem_write;
      alu_op_q    <= load_bubble ? '0 : dec_alu_op;
      dest_reg_q  <= load_bubble ? '0 : dec_dest_reg;
    end
  end

  assign instr_ready  = ready_c & rst_n;
  assign ex_valid     = ex_valid_q;
  assign reg_dst      = flags_q.reg_dst;
  assign branch       = flags_q.branch;
  assign mem_to_reg   = flags_q.mem_to_reg;
  assign alu_src      = flags_q.alu_src;
  assign reg_write    = flags_q.reg_write;
  assign mem_write    = mem_write_q;
  assign mem_rd_width = flags_q.mem_rd_width;
  assign load_signed  = flags_q.load_signed;
  assign alu_op       = alu_op_q;
  assign dest_reg     = dest_reg_q;
  assign illegal      = flags_q.illegal;
`ifdef CTRL_JUMP_EN
  assign jump         = flags_q.jump;
  assign link         = flags_q.link;
`endif

endmodule

// File: doc/ctrl_pipe_unit.md
CTRL_PIPE_UNIT -- requirements
Module: ctrl_pipe_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning the register-address width.
REQ-002 SHALL have parameter ALUOP_W, default 4, meaning the ALU-operation code width.
REQ-003 SHALL have parameter LANES, default 4, meaning the number of store byte-enable lanes.
REQ-004 SHALL have parameter FLUSH_CYC, default 1, range 1..3, meaning the number of bubble cycles inserted after a taken branch.
REQ-005 SHALL use one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port clk, input, 1 bit: the rising-edge clock.
REQ-007 SHALL have port rst_n, input, 1 bit: the asynchronous active-low reset.
REQ-008 SHALL have port instr_valid, input, 1 bit: the IF/ID instruction is valid.
REQ-009 SHALL have port instr, input, 32 bits: the MIPS instruction word (opcode [31:26], rs, rt, rd, funct [5:0]).
REQ-010 SHALL have port branch_taken, input, 1 bit: a single-cycle flush request from EX.
REQ-011 SHALL have port ext_stall, input, 1 bit: downstream hold.
REQ-012 SHALL have port instr_ready, output, 1 bit: the instruction is consumed this cycle.
REQ-013 SHALL have these registered ID/EX outputs:
- ex_valid, 1 bit
- reg_dst, branch, mem_to_reg, alu_src, reg_write, 1 bit each
- mem_write, LANES bits
- mem_rd_width, 2 bits: 0 = word, 1 = half, 2 = byte
- load_signed, 1 bit
- alu_op, ALUOP_W bits
- dest_reg, REG_AW bits
- illegal, 1 bit
REQ-014 SHALL have outputs jump and link, 1 bit each; these exist only with CTRL_JUMP_EN.

Function
REQ-015 SHALL decode LB, LH, LW, LBU, LHU, LWU, SB, SH, SW, ADDI, ANDI, ORI, XORI, SLTI, BEQ, BNE and R-type (SLL, SRL, SRA, SLLV, SRLV, SRAV, ADD, SUB, AND, OR, XOR, NOR, SLT) into:
- alu_op: 0 = SLL, 1 = SRL, 2 = SRA, 3 = ADD, 4 = SUB, 5 = AND, 6 = OR, 7 = XOR, 8 = NOR, 9 = SLT.
- Loads, stores and ADDI use ADD.
- Branches use SUB.
REQ-016 SHALL set load_signed = 1 for LB, LH and LW, and 0 for LBU, LHU and LWU.
REQ-017 SHALL set mem_write to 0001 for SB, 0011 for SH and all-ones for SW, zero-extended or truncated to LANES bits.
REQ-018 SHALL set dest_reg = rd when reg_dst = 1, and rt otherwise.
REQ-019 SHALL treat an unknown opcode or funct as illegal:
- illegal = 1 and alu_op = all ones.
- reg_write = 0, mem_write = 0, branch = 0.
- ex_valid = 1.
REQ-020 SHALL implement an FSM with states RUN, LU_STALL and FLUSH.
REQ-021 In RUN, SHALL treat a load-use hazard as: registered ex_valid & mem_to_reg & dest_reg != 0 & dest_reg in {rs, rt} of instr, with instr_valid = 1.
REQ-022 On a load-use hazard in RUN, SHALL drive instr_ready = 0, load a bubble (ex_valid = 0, all controls 0), and go to LU_STALL.
REQ-023 SHALL spend exactly one cycle in LU_STALL and then return to RUN, decoding the held instruction with no second stall.
REQ-024 SHALL, on branch_taken in any state, load a bubble, drive instr_ready = 1 (discarding the IF/ID instruction), set the flush counter to FLUSH_CYC - 1 and go to FLUSH.
REQ-025 In FLUSH, SHALL emit bubbles and drive instr_ready = 1 while the counter is nonzero, decrementing it by 1 each cycle, and return to RUN once the counter reaches 0.
REQ-026 SHALL apply ext_stall as follows:
- ID/EX registers, state and counter hold.
- instr_ready = 0.
- branch_taken still takes priority over ext_stall.
REQ-027 SHALL apply priority, highest first: rst_n, branch_taken, ext_stall, load-use, normal decode.
REQ-028 SHALL load a bubble when instr_valid = 0 in RUN, with instr_ready = 1.
REQ-029 SHALL have one-cycle latency: a decode accepted at edge N appears on the outputs after edge N.

Reset
REQ-030 SHALL, while rst_n = 0, asynchronously clear every output register to 0, the state to RUN and the counter to 0.
REQ-031 SHALL drive instr_ready = 0 during reset.
REQ-032 SHALL discard any stall or flush in progress when reset is asserted mid-operation.

Configuration
REQ-033 With CTRL_JUMP_EN defined:
- J (000010) SHALL set jump = 1.
- JAL (000011) SHALL set jump = 1, link = 1, reg_write = 1 and dest_reg = 31.
- JR (R-type funct 001000) SHALL set jump = 1 with reg_write = 0.
REQ-034 Without CTRL_JUMP_EN, SHALL omit the jump and link ports and treat J, JAL and JR as illegal per REQ-019.

Structure
REQ-035 SHALL place the opcode and funct constants, the alu_op encodings and the mem_rd_width encodings in the shared package ctrl_pkg.
REQ-036 SHALL place combinational decoding in the sub-module ctrl_decode.
REQ-037 SHALL keep the FSM, hazard compare and ID/EX registers in ctrl_pipe_unit.

Verification
REQ-038 Bench SHALL check decode: LBU 0x90430004 -> next cycle mem_to_reg = 1, mem_rd_width = 2, load_signed = 0, alu_op = 3, dest_reg = 3.
REQ-039 Bench SHALL check load-use: LW $t0 followed by ADD $t1, $t0, $t2 -> one bubble cycle with instr_ready = 0, then ADD issued, reg_dst = 1 and dest_reg = 9.
REQ-040 Bench SHALL check flush: with FLUSH_CYC = 2, a branch_taken pulse -> exactly 2 bubble cycles with instr_ready = 1, then RUN.
REQ-041 Bench SHALL check branch versus stall: branch_taken and ext_stall asserted together during LU_STALL -> FLUSH entered and bubble loaded.
REQ-042 Bench SHALL check illegal: funct 0x3F -> illegal = 1, alu_op = 0xF, reg_write = 0.
REQ-043 Bench SHALL check reset: rst_n asserted low mid-FLUSH -> all outputs 0 immediately; after release, the first valid ADDI decodes normally.
